// File: rtl/hazard_halt_unit.sv
// Pipeline hazard/halt controller: load-use stalls, redirect flushes and a
// RUN -> DRAIN -> HALTED sequence that freezes fetch and retires in-flight instructions.
module hazard_halt_unit #(
    parameter int unsigned REG_W        = 5,
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic             id_halt,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs2,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_redirect,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_bubble,
    output logic             flush_ifid,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

    localparam logic [3:0] DrainInit = 4'(DRAIN_CYCLES - 1);

    state_e           state_q, state_d;
    logic [3:0]       drain_cnt_q, drain_cnt_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic load_use;
    logic halt_go;

    assign load_use = id_valid & ex_mem_read & (ex_rd != '0) &
                      ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));

    // A halt in ID only launches once it is neither wrong-path nor waiting on a load.
    assign halt_go = id_valid & id_halt & ~load_use & ~ex_redirect;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StRun;
            drain_cnt_q   <= '0;
            halted_q      <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            drain_cnt_q   <= drain_cnt_d;
            halted_q      <= halted_d;
            stall_count_q <= stall_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        drain_cnt_d   = drain_cnt_q;
        halted_d      = halted_q;
        stall_count_d = stall_count_q;
        unique case (state_q)
            StRun: begin
                if (load_use && !ex_redirect && (stall_count_q != '1)) begin
                    stall_count_d = stall_count_q + 1'b1;
                end
                if (halt_go) begin
                    state_d     = StDrain;
                    drain_cnt_d = DrainInit;
                end
            end
            StDrain: begin
                if (drain_cnt_q == '0) begin
                    state_d  = StHalted;
                    halted_d = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q - 1'b1;
                end
            end
            StHalted: begin
                halted_d = 1'b1;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        flush_ifid  = 1'b0;
        unique case (state_q)
            StRun: begin
                if (ex_redirect) begin
                    idex_bubble = 1'b1;
                    flush_ifid  = 1'b1;
                end else if (load_use) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                end else if (halt_go) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                end
            end
            StDrain, StHalted: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
                flush_ifid  = 1'b1;
            end
            default: begin
                pc_write = 1'b1;
            end
        endcase
    end

    assign halted      = halted_q;
    assign stall_count = stall_count_q;

endmodule
